clock_enable_gen: RTL and testbench
===================================

# clock_enable_gen

Parametrised multi-channel clock-enable generator. It divides the single system clock into NUM_CH independent, phase-programmable tick streams and square-wave outputs. A `locked` flag is held low for a fixed settling interval after reset or reconfiguration. It is the all-digital successor to the fixed 50→25 MHz PLL wrapper: runtime-programmable ratios, per-channel phase and enable, and no vendor primitive.

## Interface
Parameters:
- NUM_CH, 4, number of output channels (≥1)
- DIV_W, 16, width of each divisor/phase field
- LOCK_CYCLES, 16, settling cycles before `locked` asserts (≥1)

Ports:
- refclk  in  1  system clock; the only clock
- rst  in  1  reset, synchronous, active-high
- cfg_div  in  NUM_CH*DIV_W  per-channel divisor D; channel i at [i*DIV_W +: DIV_W]
- cfg_phase  in  NUM_CH*DIV_W  per-channel start count P
- cfg_load  in  1  single-cycle strobe that captures cfg_div/cfg_phase
- ch_en  in  NUM_CH  per-channel run enable
- tick  out  NUM_CH  one-cycle pulse once per period
- outclk  out  NUM_CH  divided square wave, for use as a data signal only (not on clock nets)
- locked  out  1  configuration settled; outputs valid

## Operation
- Shadow registers hold the effective configuration:
  - div_q resets to 1 and phase_q resets to 0.
  - cfg_load=1 copies cfg_div and cfg_phase into div_q and phase_q.
  - cfg_div and cfg_phase are ignored when cfg_load=0.
- Effective divisor Deff = (div_q==0) ? 1 : div_q. Divisor 0 is legal and means 1.
- Start value S = (phase_q < Deff) ? phase_q : 0. An out-of-range phase starts at 0.
- Per-channel counter cnt, range 0..Deff-1:
  - Reset or cfg_load: cnt ← S, where S uses the newly loaded values.
  - ch_en[i]=0: cnt ← 0, held.
  - Otherwise cnt ← (cnt==Deff-1) ? 0 : cnt+1. It wraps with no overflow past Deff-1.
- Outputs are registered. Each output is computed from cnt before the edge, gated by `locked` and ch_en:
  - tick[i] ← locked & ch_en[i] & (cnt==Deff-1)
  - outclk[i] ← locked & ch_en[i] & (cnt < ((Deff+1)>>1))
  - Deff=1 gives tick and outclk constantly high. Deff=2 gives 50% duty. Odd Deff is high for one extra cycle.
- Lock sequencing uses a 2-state FSM, SETTLE and LOCKED, with lock_cnt of width $clog2(LOCK_CYCLES+1):
  - Reset → SETTLE, lock_cnt=0, locked=0.
  - In SETTLE, lock_cnt increments each cycle. On the edge where lock_cnt==LOCK_CYCLES-1: → LOCKED, locked←1.
  - cfg_load in either state → SETTLE, lock_cnt←0, locked←0.
- Simultaneous events:
  - rst beats cfg_load.
  - cfg_load beats ch_en transitions for the counter reload.
  - ch_en=0 beats the load value, so cnt=0.
- Reset values: tick=0, outclk=0, locked=0, all cnt=S(reset)=0.

## Timing
- Output latency: 1 cycle from counter state. Over any Deff consecutive cycles, tick has exactly one pulse.
- `locked` rises on the LOCK_CYCLES-th rising edge after the edge that applied rst or cfg_load, and falls on the edge that samples cfg_load.
- First tick after lock on a free-running channel occurs when cnt reaches Deff-1, i.e. phase-dependent.
- Counters run during SETTLE, so phase alignment between channels is fixed at the load edge, not at lock.
- Mid-operation rst or cfg_load takes effect on the next edge. No partial period completes.
- Re-asserting ch_en resumes from cnt=0. The first tick comes Deff cycles later, subject to the 1-cycle output register.

## Structure
- Package clock_enable_gen_pkg holds:
  - default DIV_W and LOCK_CYCLES
  - state enum {SETTLE, LOCKED}
  - function eff_div(d): maps 0→1
  - function start_cnt(p,d)
- Sub-module clock_enable_ch (one per channel, generate loop) holds div_q/phase_q slice, cnt, and registered tick/outclk. It takes locked, load and en inputs.
- The top level holds the lock FSM and the channel array.

## Test plan
- Reset, then D={1,2,3,4}, P=0, ch_en=4'hF, load pulse → locked rises 16 cycles after load. Then ch0 tick/outclk are constant 1, ch1 outclk is 1010…, ch2 outclk is 110110…, and ch3 ticks every 4th cycle.
- D=5 on ch0 and ch1 with P=0 on ch0 and P=2 on ch1 → ch1 tick leads ch0 tick by 2 cycles, every period.
- D=0 and P=7 with D=4 → ch0 behaves as D=1 and ch1 starts at cnt 0. No X values, no out-of-range cnt.
- cfg_load asserted while locked → locked drops the next cycle, all tick/outclk go to 0, and relock occurs exactly 16 cycles later with new ratios.
- ch_en[2] low for 10 cycles then high, D=4 → tick[2]=outclk[2]=0 while low. The first tick comes 4 cycles after re-enable, plus 1 register cycle.
- rst and cfg_load asserted in the same cycle mid-run → reset values result: div_q=1, locked=0, and cfg values are not captured.

Source files
------------

// File: rtl/clock_enable_gen_pkg.sv
// Shared definitions for the clock-enable generator.
//   DEF_DIV_W        default width of divisor / phase fields
//   DEF_LOCK_CYCLES  default settling interval before `locked` asserts
//   lock_state_e     lock sequencer states
//   eff_div()        effective divisor (0 is treated as 1)
//   start_cnt()      counter start value for a phase/divisor pair
// Helper functions work on 32-bit values, so DIV_W must not exceed 32.
package clock_enable_gen_pkg;

  localparam int unsigned DEF_DIV_W       = 16;
  localparam int unsigned DEF_LOCK_CYCLES = 16;

  typedef enum logic {
    SETTLE,
    LOCKED
  } lock_state_e;

  function automatic int unsigned eff_div(input int unsigned d);
    return (d == 0) ? 32'd1 : d;
  endfunction

  // An out-of-range phase starts the channel at count 0.
  function automatic int unsigned start_cnt(input int unsigned p, input int unsigned d);
    int unsigned de;
    de = eff_div(d);
    return (p < de) ? p : 32'd0;
  endfunction

endpackage

// File: rtl/clock_enable_ch.sv
// One divider channel: shadow configuration, period counter and registered
// tick / outclk outputs.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   load       configuration capture strobe
//   en         channel run enable
//   locked     lock status from the sequencer (gates the outputs)
//   cfg_div    divisor for this channel
//   cfg_phase  start count for this channel
//   tick       one-cycle pulse per period
//   outclk     divided square wave (data use only)
module clock_enable_ch
  import clock_enable_gen_pkg::*;
#(
  parameter int unsigned DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             locked,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_phase,
  output logic             tick,
  output logic             outclk
);

  localparam logic [DIV_W:0] One = 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] phase_q, phase_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] deff;
  logic [DIV_W-1:0] last;
  logic [DIV_W-1:0] start_d;
  logic [DIV_W:0]   half;
  logic             tick_q, outclk_q;

  always_comb begin
    div_d   = load ? cfg_div : div_q;
    phase_d = load ? cfg_phase : phase_q;
    // Reload value is based on the configuration being captured this edge.
    start_d = DIV_W'(start_cnt(32'(phase_d), 32'(div_d)));
    deff    = DIV_W'(eff_div(32'(div_q)));
    last    = deff - DIV_W'(1);
    // High for ceil(Deff/2) counts: odd divisors get the extra high cycle.
    half    = ({1'b0, deff} + One) >> 1;

    if (load) begin
      cnt_d = en ? start_d : '0;
    end else if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= DIV_W'(1);
      phase_q  <= '0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      outclk_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      // Outputs reflect the counter and divisor as they were before this edge.
      tick_q   <= locked & en & (cnt_q == last);
      outclk_q <= locked & en & ({1'b0, cnt_q} < half);
    end
  end

  assign tick   = tick_q;
  assign outclk = outclk_q;

endmodule

// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator: lock sequencer plus an array of
// divider channels sharing one system clock.
// Ports:
//   refclk     system clock (the only clock)
//   rst        synchronous active-high reset
//   cfg_div    packed per-channel divisors, channel i at [i*DIV_W +: DIV_W]
//   cfg_phase  packed per-channel start counts
//   cfg_load   single-cycle strobe capturing cfg_div / cfg_phase
//   ch_en      per-channel run enable
//   tick       per-channel one-cycle pulse per period
//   outclk     per-channel divided square wave (data use only)
//   locked     configuration settled, outputs valid
module clock_enable_gen
  import clock_enable_gen_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = DEF_DIV_W,
  parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic [NUM_CH*DIV_W-1:0] cfg_div,
  input  logic [NUM_CH*DIV_W-1:0] cfg_phase,
  input  logic                    cfg_load,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       outclk,
  output logic                    locked
);

  localparam int unsigned LockW = $clog2(LOCK_CYCLES + 1);

  lock_state_e      state_q;
  logic [LockW-1:0] lock_cnt_q;
  logic             locked_q;

  always_ff @(posedge refclk) begin
    if (rst || cfg_load) begin
      state_q    <= SETTLE;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      unique case (state_q)
        SETTLE: begin
          if (lock_cnt_q == LockW'(LOCK_CYCLES - 1)) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
          end else begin
            lock_cnt_q <= lock_cnt_q + LockW'(1);
          end
        end
        LOCKED: begin
          locked_q <= 1'b1;
        end
        default: begin
          state_q  <= SETTLE;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign locked = locked_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clock_enable_ch #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clk       (refclk),
      .rst       (rst),
      .load      (cfg_load),
      .en        (ch_en[i]),
      .locked    (locked_q),
      .cfg_div   (cfg_div[i*DIV_W +: DIV_W]),
      .cfg_phase (cfg_phase[i*DIV_W +: DIV_W]),
      .tick      (tick[i]),
      .outclk    (outclk[i])
    );
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Randomised + directed bench for clock_enable_gen. A reference model computes
// each channel's count in closed form (start + cycles elapsed) mod Deff and
// lock status from cycles since the last reset/load; expected outputs are
// queued per edge and a separate monitor compares them against the DUT.
module tb_clock_enable_gen;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int LC  = 16;

  logic                refclk = 1'b0;
  logic                rst = 1'b1;
  logic [NCH*DW-1:0]   cfg_div = '0;
  logic [NCH*DW-1:0]   cfg_phase = '0;
  logic                cfg_load = 1'b0;
  logic [NCH-1:0]      ch_en = '0;
  logic [NCH-1:0]      tick;
  logic [NCH-1:0]      outclk;
  logic                locked;

  clock_enable_gen #(
    .NUM_CH      (NCH),
    .DIV_W       (DW),
    .LOCK_CYCLES (LC)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .cfg_load  (cfg_load),
    .ch_en     (ch_en),
    .tick      (tick),
    .outclk    (outclk),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic [NCH-1:0] tick;
    logic [NCH-1:0] outclk;
    logic           locked;
    int             edge_no;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  bit   stim_done = 0;

  // Reference model state: count after edge `anchor` was `start`.
  int deff_m[NCH];
  int start_m[NCH];
  int anchor_m[NCH];
  int k_m = 0;
  int last_cfg_m = 0;
  bit locked_m = 0;

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int cnt_before(input int ch, input int k);
    return (start_m[ch] + (k - 1 - anchor_m[ch])) % deff_m[ch];
  endfunction

  // Model one rising edge with the given inputs; queue the expected outputs.
  task automatic model_edge(input bit r, input bit ld, input logic [NCH-1:0] en,
                            input logic [NCH*DW-1:0] dv, input logic [NCH*DW-1:0] ph);
    exp_t e;
    e.edge_no = k_m;
    e.tick = '0;
    e.outclk = '0;
    if (!r) begin
      for (int i = 0; i < NCH; i++) begin
        int c;
        c = cnt_before(i, k_m);
        e.tick[i]   = locked_m && en[i] && (c == deff_m[i] - 1);
        e.outclk[i] = locked_m && en[i] && (c < (deff_m[i] + 1) / 2);
      end
    end
    if (r || ld) last_cfg_m = k_m;
    for (int i = 0; i < NCH; i++) begin
      if (r) begin
        deff_m[i] = 1; start_m[i] = 0; anchor_m[i] = k_m;
      end else if (ld) begin
        int d, p;
        d = int'(dv[i*DW +: DW]);
        p = int'(ph[i*DW +: DW]);
        deff_m[i] = eff(d);
        start_m[i] = (en[i] && p < deff_m[i]) ? p : 0;
        anchor_m[i] = k_m;
      end else if (!en[i]) begin
        start_m[i] = 0; anchor_m[i] = k_m;
      end
    end
    locked_m = !(r || ld) && (k_m - last_cfg_m >= LC);
    e.locked = locked_m;
    exp_q.push_back(e);
    k_m++;
  endtask

  task automatic step(input bit r, input bit ld, input logic [NCH-1:0] en,
                      input logic [NCH*DW-1:0] dv, input logic [NCH*DW-1:0] ph);
    rst = r; cfg_load = ld; ch_en = en; cfg_div = dv; cfg_phase = ph;
    model_edge(r, ld, en, dv, ph);
    @(posedge refclk);
    #2;
  endtask

  task automatic idle(input int n, input logic [NCH-1:0] en);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, en, cfg_div, cfg_phase);
  endtask

  task automatic check(input string name, input int edge_no, input logic [31:0] act,
                       input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s edge %0d: got %h expected %h", name, edge_no, act, req);
    end
  endtask

  // Monitor: one output set per edge.
  initial begin
    forever begin
      @(posedge refclk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("tick", e.edge_no, 32'(tick), 32'(e.tick));
        check("outclk", e.edge_no, 32'(outclk), 32'(e.outclk));
        check("locked", e.edge_no, 32'(locked), 32'(e.locked));
      end
    end
  end

  initial begin
    logic [NCH*DW-1:0] dv, ph;
    logic [NCH-1:0]    en;
    for (int i = 0; i < NCH; i++) begin
      deff_m[i] = 1; start_m[i] = 0; anchor_m[i] = 0;
    end
    // Reset, then D={1,2,3,4}, P=0.
    step(1'b1, 1'b0, 4'h0, '0, '0);
    step(1'b1, 1'b0, 4'h0, '0, '0);
    dv = {16'd4, 16'd3, 16'd2, 16'd1};
    step(1'b0, 1'b1, 4'hF, dv, '0);
    idle(40, 4'hF);
    // Phase offset: ch1 leads ch0 by 2 on D=5.
    dv = {16'd4, 16'd3, 16'd5, 16'd5};
    ph = {16'd0, 16'd0, 16'd2, 16'd0};
    step(1'b0, 1'b1, 4'hF, dv, ph);
    idle(40, 4'hF);
    // D=0 -> 1, out-of-range phase -> start at 0.
    dv = {16'd4, 16'd4, 16'd4, 16'd0};
    ph = {16'd0, 16'd0, 16'd7, 16'd7};
    step(1'b0, 1'b1, 4'hF, dv, ph);
    idle(30, 4'hF);
    // ch2 disabled for 10 cycles then re-enabled.
    idle(10, 4'hB);
    idle(12, 4'hF);
    // Reset beats a simultaneous load.
    step(1'b1, 1'b1, 4'hF, {16'd7, 16'd7, 16'd7, 16'd7}, {16'd3, 16'd3, 16'd3, 16'd3});
    idle(25, 4'hF);
    // Randomised operation.
    en = 4'hF;
    for (int n = 0; n < 3000; n++) begin
      bit r, ld;
      r  = ($urandom_range(0, 299) == 0);
      ld = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < NCH; i++) if ($urandom_range(0, 24) == 0) en[i] = ~en[i];
      dv = cfg_div;
      ph = cfg_phase;
      if (ld) begin
        for (int i = 0; i < NCH; i++) begin
          dv[i*DW +: DW] = DW'($urandom_range(0, 9));
          ph[i*DW +: DW] = DW'($urandom_range(0, 10));
        end
      end else begin
        // Idle config bus values must be ignored.
        dv[DW-1:0] = DW'($urandom_range(0, 65535));
        ph[DW-1:0] = DW'($urandom_range(0, 65535));
      end
      step(r, ld, en, dv, ph);
    end
    stim_done = 1;
    @(posedge refclk);
    #3;
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #2000000;
    $display("FAIL timeout: stimulus_done=%0d expected 1", stim_done);
    $fatal(1, "timeout");
  end

endmodule
